// File: rtl/atm_disp_pkg.sv
// Shared types and constants for the ATM cash dispenser: FSM states,
// denomination indices/values and failure codes.
package atm_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_FEED,
    S_WAIT_ACK,
    S_DONE,
    S_FAIL
  } state_e;

  localparam logic [1:0] DEN_20 = 2'd0;
  localparam logic [1:0] DEN_10 = 2'd1;
  localparam logic [1:0] DEN_5  = 2'd2;
  localparam logic [1:0] DEN_1  = 2'd3;

  localparam int unsigned DEN_VAL [4] = '{20, 10, 5, 1};

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_SHORT = 2'd1;
  localparam logic [1:0] FC_JAM   = 2'd2;

endpackage

// File: rtl/atm_cash_dispenser_if.sv
// Controller/feeder-facing bundle of the cash dispenser; the dispenser
// takes the slave view, its driver (controller + feeder) the master view.
interface atm_cash_dispenser_if #(
  parameter int AMT_W = 6,
  parameter int CNT_W = 4
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             refill;
  logic             note_ack;
  logic             note_req;
  logic [1:0]       note_sel;
  logic             busy;
  logic             done;
  logic             fail;
  logic [1:0]       fail_code;
  logic [AMT_W-1:0] dispensed;
  logic [CNT_W-1:0] inv_20;
  logic [CNT_W-1:0] inv_10;
  logic [CNT_W-1:0] inv_5;
  logic [CNT_W-1:0] inv_1;

  modport master (
    output start, amount, refill, note_ack,
    input  note_req, note_sel, busy, done, fail, fail_code, dispensed,
           inv_20, inv_10, inv_5, inv_1
  );

  modport slave (
    input  start, amount, refill, note_ack,
    output note_req, note_sel, busy, done, fail, fail_code, dispensed,
           inv_20, inv_10, inv_5, inv_1
  );
endinterface

// File: rtl/atm_note_inventory.sv
// Per-denomination note counters: reload to INIT_CNT on reset or refill,
// single-index decrement when a note leaves the machine.
module atm_note_inventory #(
  parameter int CNT_W    = 4,
  parameter int INIT_CNT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refill,
  input  logic                  dec_en,
  input  logic [1:0]            dec_idx,
  output logic [3:0][CNT_W-1:0] cnt
);
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (refill) begin
      for (int i = 0; i < 4; i++) cnt_d[i] = CNT_W'(INIT_CNT);
    end else if (dec_en) begin
      cnt_d[dec_idx] = cnt_q[dec_idx] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= CNT_W'(INIT_CNT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/atm_cash_dispenser.sv
// Cash dispenser: plans a greedy 20/10/5/1 breakdown against inventory,
// then pays out one note per req/ack handshake with the feeder.
module atm_cash_dispenser
  import atm_disp_pkg::*;
#(
  parameter int AMT_W       = 6,
  parameter int CNT_W       = 4,
  parameter int INIT_CNT    = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  atm_cash_dispenser_if.slave bus
);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [AMT_W-1:0]      rem_q, rem_d;
  logic [AMT_W-1:0]      disp_q, disp_d;
  logic [3:0][CNT_W-1:0] plan_q, plan_d;
  logic [1:0]            pidx_q, pidx_d;
  logic [1:0]            sel_q, sel_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [1:0]            fc_q, fc_d;

  logic [3:0][CNT_W-1:0] inv_cnt;
  logic                  refill_en;
  logic                  dec_en;
  logic [AMT_W-1:0]      den, quot, inv_amt, take, rem_after;
  logic                  found;

  // Refill only from IDLE, and a simultaneous start takes priority.
  assign refill_en = (state_q == S_IDLE) && bus.refill && !bus.start;
  assign dec_en    = (state_q == S_WAIT_ACK) && bus.note_ack;

  atm_note_inventory #(
    .CNT_W   (CNT_W),
    .INIT_CNT(INIT_CNT)
  ) u_inv (
    .clk    (clk),
    .rst    (rst),
    .refill (refill_en),
    .dec_en (dec_en),
    .dec_idx(sel_q),
    .cnt    (inv_cnt)
  );

  // One greedy step for the denomination currently being planned.
  always_comb begin
    den       = AMT_W'(DEN_VAL[pidx_q]);
    quot      = rem_q / den;
    inv_amt   = AMT_W'(inv_cnt[pidx_q]);
    take      = (quot < inv_amt) ? quot : inv_amt;
    rem_after = rem_q - take * den;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    disp_d  = disp_q;
    plan_d  = plan_q;
    pidx_d  = pidx_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    fc_d    = fc_q;
    found   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = bus.amount;
          disp_d  = '0;
          fc_d    = FC_NONE;
          plan_d  = '0;
          pidx_d  = DEN_20;
          state_d = S_PLAN;
        end
      end
      S_PLAN: begin
        plan_d[pidx_q] = CNT_W'(take);
        rem_d          = rem_after;
        pidx_d         = pidx_q + 2'd1;
        if (pidx_q == DEN_1) begin
          if (rem_after != '0) begin
            fc_d    = FC_SHORT;
            state_d = S_FAIL;
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        tmo_d = '0;
        // Descending scan so the largest pending denomination wins.
        for (int i = 3; i >= 0; i--) begin
          if (plan_q[i] != '0) begin
            sel_d = 2'(i);
            found = 1'b1;
          end
        end
        state_d = found ? S_WAIT_ACK : S_DONE;
      end
      S_WAIT_ACK: begin
        if (bus.note_ack) begin
          plan_d[sel_q] = plan_q[sel_q] - CNT_W'(1);
          disp_d        = disp_q + AMT_W'(DEN_VAL[sel_q]);
          state_d       = S_FEED;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          fc_d    = FC_JAM;
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      disp_q  <= '0;
      plan_q  <= '0;
      pidx_q  <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      disp_q  <= disp_d;
      plan_q  <= plan_d;
      pidx_q  <= pidx_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.note_req  = (state_q == S_WAIT_ACK);
  assign bus.note_sel  = sel_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.fail      = (state_q == S_FAIL);
  assign bus.fail_code = fc_q;
  assign bus.dispensed = disp_q;
  assign bus.inv_20    = inv_cnt[DEN_20];
  assign bus.inv_10    = inv_cnt[DEN_10];
  assign bus.inv_5     = inv_cnt[DEN_5];
  assign bus.inv_1     = inv_cnt[DEN_1];
endmodule
